// File: rtl/ldm_stm_sequencer_pkg.sv
// Shared encodings for the LDM/STM block-transfer sequencer.
//   state_t  : sequencer FSM states
//   MODE_*   : addressing mode, encoded as {pre, up}
//   REG_PC   : register number whose load is redirected to the PC port
package ldm_stm_sequencer_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_XFER = 2'd1,
    S_WB   = 2'd2,
    S_DONE = 2'd3
  } state_t;

  localparam logic [1:0] MODE_DA = 2'b00;
  localparam logic [1:0] MODE_IA = 2'b01;
  localparam logic [1:0] MODE_DB = 2'b10;
  localparam logic [1:0] MODE_IB = 2'b11;

  localparam logic [3:0] REG_PC = 4'd15;

endpackage

// File: rtl/ldm_stm_sequencer_prio_enc16.sv
// prio_enc16: combinational lowest-set-bit finder.
//   mask  : 16-bit register mask
//   idx   : index of the lowest set bit (0 when mask is empty)
//   valid : mask has at least one bit set
module prio_enc16 (
  input  logic [15:0] mask,
  output logic [3:0]  idx,
  output logic        valid
);

  always_comb begin
    idx = 4'd0;
    // Scan downward so the lowest set bit is the last to win.
    for (int i = 15; i >= 0; i--)
      if (mask[i]) idx = 4'(i);
  end

  assign valid = |mask;

endmodule

// File: rtl/ldm_stm_sequencer.sv
// ldm_stm_sequencer: walks an LDM/STM register list one register per cycle,
// generating word addresses, register-file accesses and optional base
// writeback, and holds busy high to stall fetch/decode meanwhile.
//   clk, reset      : clock, synchronous active-low reset
//   start..reg_list : transfer request, sampled only in IDLE
//   mem_*           : data-memory address, strobes and data
//   rf_ra/rf_rd     : register-file read port (store data)
//   rf_we/wa/wd     : register-file write port (load data, base writeback)
//   pc_we/pc_wd     : load of R15
//   busy, done      : transfer in progress / one-cycle completion pulse
module ldm_stm_sequencer
  import ldm_stm_sequencer_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              is_load,
  input  logic              up,
  input  logic              pre,
  input  logic              wback,
  input  logic [3:0]        rn,
  input  logic [ADDR_W-1:0] base,
  input  logic [15:0]       reg_list,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_re,
  output logic              mem_we,
  input  logic [ADDR_W-1:0] mem_rdata,
  output logic [ADDR_W-1:0] mem_wdata,
  output logic [3:0]        rf_ra,
  input  logic [ADDR_W-1:0] rf_rd,
  output logic              rf_we,
  output logic [3:0]        rf_wa,
  output logic [ADDR_W-1:0] rf_wd,
  output logic              pc_we,
  output logic [ADDR_W-1:0] pc_wd,
  output logic              busy,
  output logic              done
);

  state_t            state;
  logic              ld_q, up_q, wb_q;
  logic [3:0]        rn_q;
  logic [ADDR_W-1:0] base_q, addr_q;
  logic [15:0]       mask_q;
  logic [4:0]        cnt_q;

  // Popcount of the incoming list as a 4-level adder tree.
  logic [1:0] pc1 [8];
  logic [2:0] pc2 [4];
  logic [3:0] pc3 [2];
  logic [4:0] cnt_in;

  always_comb begin
    for (int i = 0; i < 8; i++) pc1[i] = {1'b0, reg_list[2*i]} + {1'b0, reg_list[2*i+1]};
    for (int i = 0; i < 4; i++) pc2[i] = {1'b0, pc1[2*i]} + {1'b0, pc1[2*i+1]};
    for (int i = 0; i < 2; i++) pc3[i] = {1'b0, pc2[2*i]} + {1'b0, pc2[2*i+1]};
    cnt_in = {1'b0, pc3[0]} + {1'b0, pc3[1]};
  end

  // Lowest register sits at the lowest address, so every mode walks upward
  // from its start address; only the start point differs.
  logic [ADDR_W-1:0] off_in, start_addr;
  assign off_in = ADDR_W'({cnt_in, 2'b00});

  always_comb begin
    case ({pre, up})
      MODE_IA: start_addr = base;
      MODE_IB: start_addr = base + ADDR_W'(4);
      MODE_DA: start_addr = base - off_in + ADDR_W'(4);
      default: start_addr = base - off_in;
    endcase
  end

  logic [3:0]  idx;
  logic        idx_vld;
  logic [15:0] mask_nxt;

  prio_enc16 u_prio (.mask(mask_q), .idx(idx), .valid(idx_vld));

  assign mask_nxt = mask_q & ~(16'd1 << idx);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state  <= S_IDLE;
      ld_q   <= 1'b0;
      up_q   <= 1'b0;
      wb_q   <= 1'b0;
      rn_q   <= 4'd0;
      base_q <= '0;
      addr_q <= '0;
      mask_q <= 16'd0;
      cnt_q  <= 5'd0;
    end else begin
      case (state)
        S_IDLE: if (start) begin
          ld_q   <= is_load;
          up_q   <= up;
          // A loaded base register wins over writeback.
          wb_q   <= wback & ~(is_load & reg_list[rn]);
          rn_q   <= rn;
          base_q <= base;
          addr_q <= start_addr;
          mask_q <= reg_list;
          cnt_q  <= cnt_in;
          state  <= (reg_list == 16'd0) ? S_DONE : S_XFER;
        end
        S_XFER: begin
          mask_q <= mask_nxt;
          addr_q <= addr_q + ADDR_W'(4);
          if (mask_nxt == 16'd0) state <= wb_q ? S_WB : S_DONE;
        end
        S_WB:    state <= S_DONE;
        default: state <= S_IDLE;
      endcase
    end
  end

  logic              xfer, xld, xst, in_wb;
  logic [ADDR_W-1:0] off_q, wb_val;

  assign xfer   = (state == S_XFER) && idx_vld;
  assign xld    = xfer & ld_q;
  assign xst    = xfer & ~ld_q;
  assign in_wb  = (state == S_WB);
  assign off_q  = ADDR_W'({cnt_q, 2'b00});
  assign wb_val = up_q ? base_q + off_q : base_q - off_q;

  assign busy      = (state != S_IDLE);
  assign done      = (state == S_DONE);
  assign mem_addr  = xfer ? addr_q : '0;
  assign mem_re    = xld;
  assign mem_we    = xst;
  assign mem_wdata = rf_rd;
  assign rf_ra     = xst ? idx : 4'd0;
  assign pc_we     = xld && (idx == REG_PC);
  assign pc_wd     = pc_we ? mem_rdata : '0;
  assign rf_we     = (xld && (idx != REG_PC)) || in_wb;
  assign rf_wa     = xld ? idx : (in_wb ? rn_q : 4'd0);
  assign rf_wd     = xld ? mem_rdata : (in_wb ? wb_val : '0);

endmodule

// File: tb/tb_ldm_stm_sequencer.sv
// Directed bench for ldm_stm_sequencer. Memory returns addr ^ 0xA5A50000,
// the register file returns 0x51000000 | rf_ra, so every expected value
// below is worked out by hand from those two rules.
module tb_ldm_stm_sequencer;

  logic        clk = 1'b0;
  logic        reset, start, is_load, up, pre, wback;
  logic [3:0]  rn;
  logic [31:0] base;
  logic [15:0] reg_list;
  logic [31:0] mem_addr, mem_rdata, mem_wdata, rf_rd, rf_wd, pc_wd;
  logic        mem_re, mem_we, rf_we, pc_we, busy, done;
  logic [3:0]  rf_ra, rf_wa;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  assign mem_rdata = mem_addr ^ 32'hA5A5_0000;
  assign rf_rd     = 32'h5100_0000 | {28'd0, rf_ra};

  ldm_stm_sequencer #(.ADDR_W(32)) dut (
    .clk(clk), .reset(reset), .start(start), .is_load(is_load), .up(up),
    .pre(pre), .wback(wback), .rn(rn), .base(base), .reg_list(reg_list),
    .mem_addr(mem_addr), .mem_re(mem_re), .mem_we(mem_we),
    .mem_rdata(mem_rdata), .mem_wdata(mem_wdata), .rf_ra(rf_ra),
    .rf_rd(rf_rd), .rf_we(rf_we), .rf_wa(rf_wa), .rf_wd(rf_wd),
    .pc_we(pc_we), .pc_wd(pc_wd), .busy(busy), .done(done)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic go(input logic ld, input logic u, input logic p, input logic w,
                    input logic [3:0] r, input logic [31:0] b, input logic [15:0] l);
    start = 1'b1; is_load = ld; up = u; pre = p; wback = w;
    rn = r; base = b; reg_list = l;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, ".busy"},  {31'd0, busy},  32'd0);
    chk({tag, ".done"},  {31'd0, done},  32'd0);
    chk({tag, ".strb"},  {28'd0, mem_re, mem_we, rf_we, pc_we}, 32'd0);
    chk({tag, ".addr"},  mem_addr, 32'd0);
    chk({tag, ".ra"},    {28'd0, rf_ra}, 32'd0);
    chk({tag, ".wa"},    {28'd0, rf_wa}, 32'd0);
    chk({tag, ".wd"},    rf_wd, 32'd0);
    chk({tag, ".pcwd"},  pc_wd, 32'd0);
  endtask

  initial begin
    reset = 1'b0;
    go(1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 32'd0, 16'd0);
    start = 1'b0;
    repeat (2) step();
    chk_idle("rst");
    reset = 1'b1;
    step();

    // LDM IA, base 0x100, R1..R3, writeback to R4
    go(1'b1, 1'b1, 1'b0, 1'b1, 4'd4, 32'h100, 16'h000E);
    step(); start = 1'b0; base = 32'hDEAD_0000;
    chk("t1c1.re",   {31'd0, mem_re}, 32'd1);
    chk("t1c1.addr", mem_addr, 32'h100);
    chk("t1c1.wa",   {28'd0, rf_wa}, 32'd1);
    chk("t1c1.wd",   rf_wd, 32'hA5A5_0100);
    chk("t1c1.we",   {31'd0, rf_we}, 32'd1);
    step();
    chk("t1c2.addr", mem_addr, 32'h104);
    chk("t1c2.wd",   rf_wd, 32'hA5A5_0104);
    chk("t1c2.wa",   {28'd0, rf_wa}, 32'd2);
    step();
    chk("t1c3.addr", mem_addr, 32'h108);
    chk("t1c3.wa",   {28'd0, rf_wa}, 32'd3);
    step();
    chk("t1wb.we",   {31'd0, rf_we}, 32'd1);
    chk("t1wb.wa",   {28'd0, rf_wa}, 32'd4);
    chk("t1wb.wd",   rf_wd, 32'h10C);
    chk("t1wb.re",   {31'd0, mem_re}, 32'd0);
    chk("t1wb.busy", {31'd0, busy}, 32'd1);
    step();
    chk("t1d.done",  {31'd0, done}, 32'd1);
    chk("t1d.busy",  {31'd0, busy}, 32'd1);
    chk("t1d.we",    {31'd0, rf_we}, 32'd0);
    step();
    chk_idle("t1end");

    // STM DB, base 0x200, R0 R1 R15, writeback to R13
    go(1'b0, 1'b0, 1'b1, 1'b1, 4'd13, 32'h200, 16'h8003);
    step(); start = 1'b0;
    chk("t2c1.we",   {31'd0, mem_we}, 32'd1);
    chk("t2c1.re",   {31'd0, mem_re}, 32'd0);
    chk("t2c1.rfwe", {31'd0, rf_we}, 32'd0);
    chk("t2c1.addr", mem_addr, 32'h1F4);
    chk("t2c1.ra",   {28'd0, rf_ra}, 32'd0);
    chk("t2c1.wdat", mem_wdata, 32'h5100_0000);
    step();
    chk("t2c2.addr", mem_addr, 32'h1F8);
    chk("t2c2.ra",   {28'd0, rf_ra}, 32'd1);
    step();
    chk("t2c3.addr", mem_addr, 32'h1FC);
    chk("t2c3.ra",   {28'd0, rf_ra}, 32'd15);
    chk("t2c3.wdat", mem_wdata, 32'h5100_000F);
    chk("t2c3.pcwe", {31'd0, pc_we}, 32'd0);
    step();
    chk("t2wb.wa",   {28'd0, rf_wa}, 32'd13);
    chk("t2wb.wd",   rf_wd, 32'h1F4);
    chk("t2wb.mwe",  {31'd0, mem_we}, 32'd0);
    step();
    chk("t2d.done",  {31'd0, done}, 32'd1);
    step();
    chk("t2end.busy", {31'd0, busy}, 32'd0);

    // LDM with base R2 in the list: writeback suppressed
    go(1'b1, 1'b1, 1'b0, 1'b1, 4'd2, 32'h300, 16'h0004);
    step(); start = 1'b0;
    chk("t3c1.wa",   {28'd0, rf_wa}, 32'd2);
    chk("t3c1.wd",   rf_wd, 32'hA5A5_0300);
    chk("t3c1.we",   {31'd0, rf_we}, 32'd1);
    step();
    chk("t3d.done",  {31'd0, done}, 32'd1);
    chk("t3d.we",    {31'd0, rf_we}, 32'd0);
    // request presented in DONE must wait for IDLE
    go(1'b1, 1'b1, 1'b1, 1'b0, 4'd0, 32'h400, 16'h8000);
    step();
    chk("t3end.busy", {31'd0, busy}, 32'd0);
    chk("t3end.done", {31'd0, done}, 32'd0);

    // LDM IB of R15 only: PC port, no register-file write
    step(); start = 1'b0;
    chk("t4c1.addr", mem_addr, 32'h404);
    chk("t4c1.pcwe", {31'd0, pc_we}, 32'd1);
    chk("t4c1.pcwd", pc_wd, 32'hA5A5_0404);
    chk("t4c1.rfwe", {31'd0, rf_we}, 32'd0);
    chk("t4c1.re",   {31'd0, mem_re}, 32'd1);
    step();
    chk("t4d.done",  {31'd0, done}, 32'd1);
    chk("t4d.pcwe",  {31'd0, pc_we}, 32'd0);
    step();

    // LDM DA, base 0x500, R0 R4, writeback to R5
    go(1'b1, 1'b0, 1'b0, 1'b1, 4'd5, 32'h500, 16'h0011);
    step(); start = 1'b0;
    chk("t5c1.addr", mem_addr, 32'h4FC);
    chk("t5c1.wa",   {28'd0, rf_wa}, 32'd0);
    chk("t5c1.wd",   rf_wd, 32'hA5A5_04FC);
    step();
    chk("t5c2.addr", mem_addr, 32'h500);
    chk("t5c2.wa",   {28'd0, rf_wa}, 32'd4);
    step();
    chk("t5wb.wa",   {28'd0, rf_wa}, 32'd5);
    chk("t5wb.wd",   rf_wd, 32'h4F8);
    step();
    chk("t5d.done",  {31'd0, done}, 32'd1);
    step();

    // empty list: straight to DONE, no strobes
    go(1'b0, 1'b1, 1'b0, 1'b1, 4'd3, 32'h700, 16'h0000);
    step(); start = 1'b0;
    chk("t6.done",   {31'd0, done}, 32'd1);
    chk("t6.busy",   {31'd0, busy}, 32'd1);
    chk("t6.strb",   {28'd0, mem_re, mem_we, rf_we, pc_we}, 32'd0);
    step();
    chk_idle("t6end");

    // reset in the 2nd XFER cycle of a 4-register LDM
    go(1'b1, 1'b1, 1'b0, 1'b1, 4'd1, 32'h600, 16'h00F0);
    step();
    chk("t7c1.wa",   {28'd0, rf_wa}, 32'd4);
    // restart attempt while busy must be ignored
    go(1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 32'h900, 16'h0001);
    step(); start = 1'b0;
    chk("t7c2.wa",   {28'd0, rf_wa}, 32'd5);
    chk("t7c2.addr", mem_addr, 32'h604);
    reset = 1'b0;
    step();
    chk_idle("t7rst");
    reset = 1'b1;
    step();
    chk_idle("t7post");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/ldm_stm_sequencer.md
# ldm_stm_sequencer

Multi-cycle sequencer for ARM block transfers (LDM/STM) in the pipeline core. It walks a 16-bit register list one register per cycle and generates word addresses for data memory. It drives the register-file write port for loads and the register-file read address for stores, then performs optional base writeback. While a transfer is in progress it stalls the front of the pipeline.

## Interface
Parameters:
- `ADDR_W`, 32: address/data width.

Ports:
- `clk`  in  1: single clock, all state updates on rising edge.
- `reset`  in  1: synchronous, active-low; sampled on rising edge of `clk`.
- `start`  in  1: request from decode; accepted only in IDLE.
- `is_load`  in  1: 1 = LDM, 0 = STM.
- `up`  in  1: U bit, 1 = increment.
- `pre`  in  1: P bit, 1 = before.
- `wback`  in  1: W bit.
- `rn`  in  4: base register number.
- `base`  in  32: base register value, sampled with `start`.
- `reg_list`  in  16: register mask, sampled with `start`.
- `mem_addr`  out  32: word address of current transfer.
- `mem_re` / `mem_we`  out  1: memory read/write strobe.
- `mem_rdata`  in  32: read data, valid combinationally in the same cycle.
- `mem_wdata`  out  32: store data, equal to `rf_rd`.
- `rf_ra`  out  4: register-file read address for stores.
- `rf_rd`  in  32: register-file read data.
- `rf_we`, `rf_wa` (4), `rf_wd` (32)  out: register-file write port.
- `pc_we`, `pc_wd` (32)  out: load of R15.
- `busy`  out  1: high whenever state ≠ IDLE; stalls fetch/decode.
- `done`  out  1: one-cycle completion pulse.

## Operation
- States: IDLE → XFER → (WB if `wback` and not suppressed) → DONE → IDLE.
- On `start` in IDLE:
  - Latch `is_load`, `up`, `pre`, `wback`, `rn`, `base`, `reg_list`.
  - `count` = popcount(`reg_list`), a 5-bit value, 0..16.
- Start address, with all arithmetic mod 2^32:
  - IA: `base`.
  - IB: `base`+4.
  - DA: `base`−4·count+4.
  - DB: `base`−4·count.
- XFER, one cycle per set bit, lowest register number first at the lowest address; address advances by +4 each transfer.
  - Load: `mem_re`=1, `rf_we`=1, `rf_wa`=reg, `rf_wd`=`mem_rdata`. For reg 15: `rf_we`=0 and `pc_we`=1, `pc_wd`=`mem_rdata`.
  - Store: `mem_we`=1, `rf_ra`=reg, `mem_wdata`=`rf_rd`.
  - Serviced bit is cleared from the working mask. Leave XFER when the mask becomes zero.
- WB: `rf_we`=1, `rf_wa`=`rn`, `rf_wd`=`base`±4·count.
- WB is suppressed when `is_load` and `reg_list[rn]`: the loaded value wins.
- Empty `reg_list`: IDLE → DONE directly. No memory access and no writeback.
- `start` while busy is ignored. Inputs other than `mem_rdata`/`rf_rd` are ignored outside IDLE.
- All strobes (`mem_re`, `mem_we`, `rf_we`, `pc_we`) are 0 in IDLE and DONE.

## Timing
- Reset, `reset`=0 at a rising edge: state=IDLE and every output 0 (`mem_addr`, `rf_ra`, `rf_wa`, `rf_wd`, `pc_wd`, `busy`, `done`, all strobes).
- Reset mid-transfer aborts immediately. No further strobes; partial register writes already done stand.
- `start` at edge k: first XFER cycle is k+1.
- Total busy cycles: count + (1 if WB) + 1 for DONE.
- `done` is high exactly in the DONE cycle. `busy` falls the following edge. A new `start` may be presented in the DONE cycle but is accepted only in IDLE.
- Outputs are combinational from registered state and latched operands. Register-file writes land on its negedge within the same cycle.

## Structure
- Shared core package:
  - State encoding localparams: IDLE, XFER, WB, DONE.
  - Mode encoding `{pre, up}`.
  - `REG_PC` = 4'd15.
- One sub-module: `prio_enc16`, a combinational lowest-set-bit finder (16-bit mask → 4-bit index + valid). Reused for popcount-free iteration.
- Popcount is computed inline as an adder tree.

## Test plan
- LDM IA, `base`=0x100, list 0x000E, W=1, mem[0x100..0x108]=A,B,C:
  - R1=A, R2=B, R3=C at 0x100/0x104/0x108.
  - WB writes R`rn`=0x10C.
  - `busy` for 5 cycles, `done` in cycle 5.
- STM DB, `base`=0x200, list 0x8003, W=1:
  - Writes at 0x1F4/0x1F8/0x1FC carry R0, R1, R15 (`rf_ra` 0,1,15).
  - WB value 0x1F4.
- LDM with `rn`=2, list 0x0004, W=1: R2 ← memory; WB cycle absent; `busy` for 2 cycles.
- LDM IB list 0x8000: `pc_we`=1 with `pc_wd`=mem[base+4]; `rf_we`=0.
- Empty list: `done` at cycle k+1; no strobes ever asserted.
- `reset`=0 in 2nd XFER cycle of a 4-register LDM: next cycle all outputs 0 and state IDLE. `start` reasserted during busy is ignored.
